// File: rtl/riscv_checkpoint_monitor.sv
// Checkpoint monitor for RISCV_TOP: matches OUTPUT_PORT against a loadable table
// of (instruction count, expected value) pairs while the core runs, tallies
// passes and failures, enforces a cycle timeout and reports a final verdict.
//
// Handshake: there is no valid/ready pair here. TBL_WE, TBL_CLR and START are
// single-cycle strobes sampled at CLK; table strobes act only outside RUN and
// START acts only outside RUN. NUM_INST/OUTPUT_PORT/HALT are sampled every RUN
// cycle with no backpressure.
module riscv_checkpoint_monitor #(
  parameter int NUM_CHK      = 40,
  parameter int IDX_W        = 6,
  parameter int DATA_W       = 32,
  parameter int MAX_CYCLES   = 1000000,
  parameter int STOP_ON_FAIL = 1,
  parameter int REQUIRE_ALL  = 0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              TBL_WE,
  input  logic [IDX_W-1:0]  TBL_ADDR,
  input  logic [DATA_W-1:0] TBL_INST,
  input  logic [DATA_W-1:0] TBL_ANS,
  input  logic              TBL_CLR,
  input  logic              START,
  input  logic [DATA_W-1:0] NUM_INST,
  input  logic [DATA_W-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic              FAIL,
  output logic              TIMEOUT,
  output logic [IDX_W-1:0]  FAIL_IDX,
  output logic [DATA_W-1:0] FAIL_VAL,
  output logic [IDX_W:0]    PASS_CNT,
  output logic [IDX_W:0]    FAIL_CNT,
  output logic [31:0]       CYCLE,
  output logic [1:0]        STATE_DBG
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state;
  logic [NUM_CHK-1:0]  valid;
  logic [NUM_CHK-1:0]  visited;
  logic [DATA_W-1:0]   inst_mem [NUM_CHK];
  logic [DATA_W-1:0]   ans_mem  [NUM_CHK];

  logic [NUM_CHK-1:0]  fire;
  logic [NUM_CHK-1:0]  hit;
  logic [NUM_CHK-1:0]  miss;
  logic [NUM_CHK-1:0]  absent;
  logic [IDX_W:0]      n_hit;
  logic [IDX_W:0]      n_miss;
  logic [IDX_W:0]      n_absent;
  logic [IDX_W-1:0]    miss_low;
  logic [IDX_W-1:0]    absent_low;
  logic [IDX_W:0]      fail_cnt_nxt;
  logic                timeout_hit;
  logic                stop_run;
  logic                addr_ok;
  logic                verdict_pass;

  assign STATE_DBG = state;

  // Per-entry compare; scanning high to low leaves the lowest index in *_low.
  always_comb begin
    fire       = '0;
    hit        = '0;
    miss       = '0;
    absent     = '0;
    n_hit      = '0;
    n_miss     = '0;
    n_absent   = '0;
    miss_low   = '0;
    absent_low = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      fire[i]   = valid[i] && !visited[i] && (NUM_INST == inst_mem[i]);
      hit[i]    = fire[i] && (OUTPUT_PORT == ans_mem[i]);
      miss[i]   = fire[i] && (OUTPUT_PORT != ans_mem[i]);
      absent[i] = valid[i] && !visited[i] && !fire[i];
      if (hit[i]) n_hit = n_hit + (IDX_W+1)'(1);
      if (miss[i]) begin
        n_miss   = n_miss + (IDX_W+1)'(1);
        miss_low = IDX_W'(i);
      end
      if (absent[i]) begin
        n_absent   = n_absent + (IDX_W+1)'(1);
        absent_low = IDX_W'(i);
      end
    end
  end

  // Next failure count, timeout and end-of-run decisions for the current RUN cycle.
  always_comb begin
    fail_cnt_nxt = FAIL_CNT + n_miss;
    if (HALT && (REQUIRE_ALL != 0)) fail_cnt_nxt = fail_cnt_nxt + n_absent;
    timeout_hit  = (MAX_CYCLES > 0) && !HALT && (CYCLE == 32'(MAX_CYCLES - 1));
    stop_run     = HALT || ((STOP_ON_FAIL != 0) && (n_miss != '0)) || timeout_hit;
    verdict_pass = (fail_cnt_nxt == '0) && !timeout_hit;
    addr_ok      = ({1'b0, TBL_ADDR} < (IDX_W+1)'(NUM_CHK));
  end

  // Table payload storage; only the valid bits need a reset.
  always_ff @(posedge CLK) begin
    if ((state != S_RUN) && TBL_WE && !TBL_CLR && addr_ok) begin
      inst_mem[TBL_ADDR] <= TBL_INST;
      ans_mem[TBL_ADDR]  <= TBL_ANS;
    end
  end

  // Control FSM with registered status, counters and failure log.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= S_IDLE;
      valid    <= '0;
      visited  <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      FAIL     <= 1'b0;
      TIMEOUT  <= 1'b0;
      FAIL_IDX <= '0;
      FAIL_VAL <= '0;
      PASS_CNT <= '0;
      FAIL_CNT <= '0;
      CYCLE    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (TBL_CLR) valid <= '0;
          else if (TBL_WE && addr_ok) valid[TBL_ADDR] <= 1'b1;
          if (START) begin
            state    <= S_RUN;
            visited  <= '0;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            FAIL     <= 1'b0;
            TIMEOUT  <= 1'b0;
            FAIL_IDX <= '0;
            FAIL_VAL <= '0;
            PASS_CNT <= '0;
            FAIL_CNT <= '0;
            CYCLE    <= '0;
          end
        end
        S_RUN: begin
          visited  <= visited | fire;
          PASS_CNT <= PASS_CNT + n_hit;
          FAIL_CNT <= fail_cnt_nxt;
          if (CYCLE != '1) CYCLE <= CYCLE + 32'd1;
          // An empty failure count means nothing has been logged yet this run.
          if (FAIL_CNT == '0) begin
            if (n_miss != '0) begin
              FAIL_IDX <= miss_low;
              FAIL_VAL <= OUTPUT_PORT;
            end else if (HALT && (REQUIRE_ALL != 0) && (n_absent != '0)) begin
              FAIL_IDX <= absent_low;
              FAIL_VAL <= '0;
            end
          end
          if (stop_run) begin
            state   <= S_DONE;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            TIMEOUT <= timeout_hit;
            PASS    <= verdict_pass;
            FAIL    <= !verdict_pass;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
